day_4_loader: RTL and testbench

Upstream input stage for the day-4 grid solver. Accepts the puzzle text as a byte stream (`@`, `.`, newline), packs each line into a WIDTH-bit row and writes rows in order to the solver's row memory. Also counts occupied cells and flags malformed input. Replaces the simulation-only memory-image preload, so the solver can be fed at run time.

---
 rtl/day_4_pkg.sv | 20 ++
 rtl/day_4_loader.sv | 144 ++++++++++++++
 tb/tb_day_4_loader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/day_4_pkg.sv
// Shared constants for the day-4 grid loader and solver.
// Grid size defaults, ASCII codes and the loader state type.
package day_4_pkg;

  localparam int D4_WIDTH  = 140;
  localparam int D4_HEIGHT = 140;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/day_4_loader.sv
// Packs the '@'/'.' puzzle text stream into WIDTH-bit rows for the solver.
// Ports: clk/rst, start, in_* byte stream, row_* write port, cell_count, done, error.
module day_4_loader
  import day_4_pkg::*;
#(
  parameter int WIDTH  = D4_WIDTH,
  parameter int HEIGHT = D4_HEIGHT,
  parameter int CNT_W  = 15,
  parameter int ROW_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              row_we,
  output logic [ROW_AW-1:0] row_addr,
  output logic [WIDTH-1:0]  row_data,
  output logic [CNT_W-1:0]  cell_count,
  output logic              done,
  output logic              error
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIDTH);
  localparam logic [COL_W-1:0] COL_PEN  = COL_W'(WIDTH - 1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(HEIGHT - 1);

  state_t              state, state_d;
  logic [COL_W-1:0]    col, col_d;
  logic [ROW_AW-1:0]   row, row_d;
  logic [WIDTH-1:0]    sr, sr_d, sr_shift;
  logic [CNT_W-1:0]    cnt_d;
  logic [ROW_AW-1:0]   addr_d;
  logic [WIDTH-1:0]    data_d;
  logic                we_d, done_d, err_d;
  logic                acc, is_roll, is_cell;
  logic                is_lf, is_cr;
  logic                full, last_row;
  logic                bad, complete;

  // A start pulse in LOAD wins over a byte in the same cycle,
  // so the byte is never half-accepted by a discarded load.
  assign in_ready = (state == S_LOAD) && !start;
  assign acc      = in_valid && in_ready;
  assign is_roll  = in_data == CH_ROLL;
  assign is_cell  = is_roll || (in_data == CH_EMPTY);
  assign is_lf    = in_data == CH_LF;
  assign is_cr    = in_data == CH_CR;
  assign full     = col == COL_FULL;
  assign last_row = row == ROW_LAST;
  assign sr_shift = {sr[WIDTH-2:0], is_roll};

  // in_last must land on the byte that completes the final row.
  // A blank line is only tolerated before the first row.
  always_comb begin
    bad      = 1'b0;
    complete = 1'b0;
    unique case (1'b1)
      is_cell: begin
        bad = full ||
          (in_last && !(col == COL_PEN && last_row));
        complete = in_last && !bad;
      end
      is_lf: begin
        complete = full;
        bad = (!full && !(col == '0 && row == '0)) ||
          (in_last && !(full && last_row));
      end
      is_cr: bad = in_last;
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    col_d   = col;
    row_d   = row;
    sr_d    = sr;
    cnt_d   = cell_count;
    we_d    = 1'b0;
    addr_d  = row_addr;
    data_d  = row_data;
    done_d  = done || (state == S_DONE && row_we);
    err_d   = error;
    if (start) begin
      state_d = S_LOAD;
      col_d   = '0;
      row_d   = '0;
      sr_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (acc) begin
      if (bad) begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end else begin
        if (is_cell) begin
          sr_d  = sr_shift;
          col_d = col + 1'b1;
          if (is_roll) cnt_d = cell_count + 1'b1;
        end
        if (complete) begin
          we_d   = 1'b1;
          addr_d = row;
          data_d = is_cell ? sr_shift : sr;
          row_d  = row + 1'b1;
          col_d  = '0;
          if (last_row) state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      sr         <= '0;
      cell_count <= '0;
      row_we     <= 1'b0;
      row_addr   <= '0;
      row_data   <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      col        <= col_d;
      row        <= row_d;
      sr         <= sr_d;
      cell_count <= cnt_d;
      row_we     <= we_d;
      row_addr   <= addr_d;
      row_data   <= data_d;
      done       <= done_d;
      error      <= err_d;
    end
  end

endmodule

// File: tb/tb_day_4_loader.sv
// Scoreboard bench for day_4_loader on a 4x3 grid.
// A line-level text model queues expected row writes; a monitor checks them.
module tb_day_4_loader;
  import day_4_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 15;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last;
  logic [7:0]    in_data;
  logic          in_ready, row_we, done, error;
  logic [AW-1:0] row_addr;
  logic [W-1:0]  row_data;
  logic [CW-1:0] cell_count;

  always #5 clk = ~clk;

  day_4_loader #(
    .WIDTH(W), .HEIGHT(H), .CNT_W(CW), .ROW_AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .row_we(row_we), .row_addr(row_addr),
    .row_data(row_data), .cell_count(cell_count),
    .done(done), .error(error)
  );

  typedef struct {
    int           addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit  exp_err, exp_done;
  int  exp_cnt;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && row_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_row_we", row_addr, -1);
      end else begin
        automatic wr_t e = exp_q.pop_front();
        chk("row_addr", row_addr, e.addr);
        chk("row_data", row_data, e.data);
      end
    end
  end

  function automatic bit line_ok(input byte l[$]);
    if (l.size() != W) return 1'b0;
    foreach (l[k])
      if (l[k] != CH_ROLL && l[k] != CH_EMPTY)
        return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] pack(input byte l[$]);
    logic [W-1:0] v = '0;
    foreach (l[k]) v[W-1-k] = (l[k] == CH_ROLL);
    return v;
  endfunction

  // Split the text into lines (CR dropped) and judge each whole line.
  // ends=0: the stream is only a prefix, so no end-of-file rules.
  function automatic void model(input byte s[$],
                                input bit ends);
    byte cur[$];
    int  rows, n;
    bit  err, fin;
    rows = 0; err = 0; n = s.size();
    exp_cnt = 0; cur = {};
    for (int i = 0; i <= n; i++) begin
      if (err || rows == H) break;
      if (i < n && s[i] == CH_CR) continue;
      if (i < n && s[i] != CH_LF) begin
        cur.push_back(s[i]);
        continue;
      end
      if (i == n && (!ends || cur.size() == 0)) break;
      if (i < n && rows == 0 && cur.size() == 0) continue;
      fin = ends && (i >= n - 1);
      if (!line_ok(cur) || (fin && rows != H - 1) ||
          (i == n && s[n-1] == CH_CR)) begin
        err = 1;
      end else begin
        exp_q.push_back('{rows, pack(cur)});
        foreach (cur[k]) if (cur[k] == CH_ROLL) exp_cnt++;
        rows++;
      end
      cur = {};
    end
    if (ends && !err && rows < H) err = 1;
    exp_err  = err;
    exp_done = (rows == H);
  endfunction

  function automatic void build(input logic [W-1:0] g[H],
                                input bit crlf,
                                input bit tail_lf,
                                input bit lead,
                                input bit junk,
                                output byte s[$]);
    s = {};
    if (lead) s.push_back(CH_LF);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++)
        s.push_back(g[r][W-1-c] ? CH_ROLL : CH_EMPTY);
      if (r < H - 1 || tail_lf) begin
        if (crlf) s.push_back(CH_CR);
        s.push_back(CH_LF);
      end
    end
    if (junk) begin
      s.push_back(CH_ROLL);
      s.push_back(CH_EMPTY);
      s.push_back(CH_LF);
    end
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_ready", in_ready, 1);
    chk("start_count", cell_count, 0);
    chk("start_flags", {done, error}, 0);
  endtask

  task automatic drive(input byte s[$], input int max_acc,
                       input bit gaps,
                       output bit ended, output int nacc);
    int n;
    n = s.size();
    ended = 0; nacc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = (i == n - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
      nacc++;
      if (nacc == max_acc) break;
      @(negedge clk);
      if (!in_ready) begin
        ended = 1;
        break;
      end
    end
  endtask

  task automatic scenario(input string name, input byte s[$],
                          input bit gaps);
    bit ended;
    int nacc;
    model(s, 1'b1);
    do_start();
    drive(s, 1 << 30, gaps, ended, nacc);
    chk({name, "_ended"}, ended, 1);
    chk({name, "_err_lat"}, error, exp_err);
    chk({name, "_done_lat"}, done, 0);
    @(negedge clk);
    chk({name, "_done"}, done, exp_done);
    chk({name, "_error"}, error, exp_err);
    chk({name, "_ready"}, in_ready, 0);
    chk({name, "_we_low"}, row_we, 0);
    if (!exp_err) chk({name, "_count"}, cell_count, exp_cnt);
    repeat (2) @(negedge clk);
    chk({name, "_missing"}, exp_q.size(), 0);
    exp_q = {};
  endtask

  byte s[$];
  byte p[$];
  logic [W-1:0] g[H];
  logic [W-1:0] spec_g[H];
  byte bad_set[7];

  initial begin
    bit ended;
    int nacc;
    spec_g[0] = 4'hB; spec_g[1] = 4'h0; spec_g[2] = 4'hF;
    bad_set = '{8'h23, 8'h00, 8'hFF, CH_LF,
                CH_ROLL, CH_EMPTY, 8'h41};
    rst = 1'b1; start = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", row_we, 0);
    chk("rst_addr", row_addr, 0);
    chk("rst_data", row_data, 0);
    chk("rst_count", cell_count, 0);
    chk("rst_flags", {done, error}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    build(spec_g, 0, 1, 0, 0, s);
    scenario("grid_lf", s, 0);
    chk("grid_lf_cnt7", cell_count, 7);

    build(spec_g, 0, 0, 0, 0, s);
    scenario("grid_nolf", s, 0);

    s = {CH_ROLL, CH_EMPTY, CH_ROLL, CH_LF};
    scenario("short_line", s, 0);

    s = {CH_ROLL, CH_ROLL, CH_ROLL, CH_ROLL, CH_ROLL};
    scenario("long_line", s, 0);

    build(spec_g, 1, 1, 0, 0, s);
    scenario("crlf_gaps", s, 1);

    build(spec_g, 0, 1, 1, 1, s);
    scenario("lead_junk", s, 1);

    for (int t = 0; t < 12; t++) begin
      bit crlf, tail, lead, junk;
      for (int r = 0; r < H; r++) g[r] = W'($urandom);
      crlf = 1'($urandom);
      tail = 1'($urandom);
      lead = 1'($urandom);
      junk = tail && 1'($urandom);
      build(g, crlf, tail, lead, junk, s);
      if ($urandom_range(0, 1) == 1)
        s[$urandom_range(0, s.size() - 1)] =
          bad_set[$urandom_range(0, 6)];
      scenario("rand", s, 1);
    end

    build(spec_g, 0, 1, 0, 0, s);
    p = s[0:5];
    model(p, 1'b0);
    do_start();
    drive(s, 6, 0, ended, nacc);
    chk("pre_rst_acc", nacc, 6);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_we", row_we, 0);
    chk("mid_rst_addr", row_addr, 0);
    chk("mid_rst_data", row_data, 0);
    chk("mid_rst_count", cell_count, 0);
    chk("mid_rst_flags", {done, error}, 0);
    chk("pre_rst_writes", exp_q.size(), 0);
    exp_q = {};
    @(posedge clk); #1;
    rst = 1'b0;
    scenario("after_rst", s, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
